// File: rtl/useq.sv
// useq: 65C02 microcode sequencer driving a synchronous microcode ROM (address out, word back one cycle later).
// Define USEQ_STACK_EN to build the micro-subroutine stack; otherwise CALL acts as NEXT, RETURN as DECODE, err is 0.
module useq #(
    parameter int                ADDR_W      = 9,
    parameter int                CW          = 36,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ENTRY = 9'h160,
    parameter logic [ADDR_W-1:0] IRQ_ENTRY   = 9'h168,
    parameter logic [ADDR_W-1:0] NMI_ENTRY   = 9'h170
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic              irq,
    input  logic              nmi,
    input  logic              I,
    input  logic              D,
    input  logic              cond,
    input  logic [7:0]        DB,
    input  logic [CW-1:0]     ucode,
    output logic [ADDR_W-1:0] upc,
    output logic [CW-5:0]     cw,
    output logic              sync,
    output logic              we,
    output logic              err
);
    localparam int NXT_W = ADDR_W - 2;
    localparam int FIN_W = ADDR_W - 4;

    localparam logic [2:0] SEQ_DECODE    = 3'b000;
    localparam logic [2:0] SEQ_NEXT      = 3'b001;
    localparam logic [2:0] SEQ_FINISH    = 3'b010;
    localparam logic [2:0] SEQ_NEXT_SAVE = 3'b011;
    localparam logic [2:0] SEQ_BRANCH    = 3'b100;
    localparam logic [2:0] SEQ_CALL      = 3'b101;
    localparam logic [2:0] SEQ_RETURN    = 3'b110;
    localparam logic [2:0] SEQ_HALT      = 3'b111;

    if (ADDR_W < 9 || STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_param_check
        $error("useq: ADDR_W must be >= 9 and STACK_DEPTH a power of 2 >= 2");
    end

    logic [2:0]        seq;
    logic              we_nxt;
    logic [NXT_W-1:0]  nxt;
    logic [FIN_W-1:0]  fin;
    logic [ADDR_W-1:0] upc_q;
    logic [FIN_W-1:0]  finish;
    logic              nmi_q;
    logic              nmi_pend;
    logic              clr_nmi;
    logic              save_fin;
    logic              irq_take;
    logic [ADDR_W-1:0] dec_addr;
    logic [ADDR_W-1:0] uc_addr;
    logic [ADDR_W-1:0] fin_addr;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] int_addr;

    assign seq      = ucode[CW-1:CW-3];
    assign we_nxt   = ucode[CW-4];
    assign nxt      = ucode[NXT_W-1:0];
    assign fin      = ucode[NXT_W+FIN_W-1:NXT_W];
    assign cw       = ucode[CW-5:0];
    assign sync     = (seq == SEQ_DECODE);

    assign dec_addr = {{(ADDR_W-8){1'b0}}, DB};
    assign uc_addr  = {1'b1, D, nxt};
    assign fin_addr = {1'b1, D, 2'b10, finish};
    assign seq_addr = upc_q + ADDR_W'(1);
    assign irq_take = irq & ~I;

    // A pending NMI always beats IRQ; only a maskable IRQ honours I.
    always_comb begin
        int_addr = dec_addr;
        if (nmi_pend)
            int_addr = NMI_ENTRY;
        else if (irq_take)
            int_addr = IRQ_ENTRY;
    end

`ifdef USEQ_STACK_EN
    localparam int SP_W    = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = SP_W + 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0]  stack [STACK_DEPTH];
    logic [SP_W-1:0]    sp;
    logic [DEPTH_W-1:0] depth;
    logic               err_q;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  pop_addr;

    assign pop_addr = stack[sp - 1'b1];
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    always_comb begin
        upc      = upc_q;
        save_fin = 1'b0;
        clr_nmi  = 1'b0;
`ifdef USEQ_STACK_EN
        push     = 1'b0;
        pop      = 1'b0;
`endif
        if (reset) begin
            upc = RESET_ENTRY;
        end else if (rdy) begin
            case (seq)
                SEQ_DECODE: begin
                    upc     = int_addr;
                    clr_nmi = nmi_pend;
                end
                SEQ_NEXT:   upc = uc_addr;
                SEQ_FINISH: upc = fin_addr;
                SEQ_NEXT_SAVE: begin
                    upc      = uc_addr;
                    save_fin = 1'b1;
                end
                SEQ_BRANCH: upc = cond ? uc_addr : seq_addr;
`ifdef USEQ_STACK_EN
                SEQ_CALL: begin
                    upc  = uc_addr;
                    push = 1'b1;
                end
                SEQ_RETURN: begin
                    upc = pop_addr;
                    pop = 1'b1;
                end
`else
                SEQ_CALL:   upc = uc_addr;
                SEQ_RETURN: begin
                    upc     = int_addr;
                    clr_nmi = nmi_pend;
                end
`endif
                SEQ_HALT: begin
                    // Any irq wakes; a masked irq just falls through to nxt.
                    if (nmi_pend | irq) begin
                        upc     = (nmi_pend | irq_take) ? int_addr : uc_addr;
                        clr_nmi = nmi_pend;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        upc_q <= upc;
        if (reset) begin
            finish   <= '0;
            we       <= 1'b0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_q <= nmi;
            // A fresh edge wins over a same-cycle clear.
            if (nmi & ~nmi_q)
                nmi_pend <= 1'b1;
            else if (clr_nmi)
                nmi_pend <= 1'b0;
            if (rdy) begin
                we <= we_nxt;
                if (save_fin)
                    finish <= fin;
            end
        end
    end

`ifdef USEQ_STACK_EN
    always_ff @(posedge clk) begin
        if (push)
            stack[sp] <= seq_addr;
    end

    // Full push overwrites the oldest slot (sp wraps onto it); empty pop still moves sp.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            depth <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            sp <= sp + 1'b1;
            if (depth == FULL)
                err_q <= 1'b1;
            else
                depth <= depth + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
            if (depth == '0)
                err_q <= 1'b1;
            else
                depth <= depth - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_useq.sv
// tb_useq: directed bench for useq with a bench-side microcode ROM, a queue-based sequencer model
// checked every cycle, and hand-computed address expectations along the directed walk.
module tb_useq;
  localparam logic [8:0] RST_A = 9'h160;
  localparam logic [8:0] IRQ_A = 9'h168;
  localparam logic [8:0] NMI_A = 9'h170;
  localparam logic [2:0] S_DEC  = 3'd0;
  localparam logic [2:0] S_NEXT = 3'd1;
  localparam logic [2:0] S_FIN  = 3'd2;
  localparam logic [2:0] S_SAVE = 3'd3;
  localparam logic [2:0] S_BR   = 3'd4;
  localparam logic [2:0] S_CALL = 3'd5;
  localparam logic [2:0] S_RET  = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  logic        clk = 1'b0;
  logic        reset, rdy, irq, nmi, I, D, cond;
  logic [7:0]  DB;
  logic [35:0] ucode;
  logic [8:0]  upc;
  logic [31:0] cw;
  logic        sync, we, err;

  int n_cmp = 0;
  int n_fail = 0;

  useq dut (
    .clk(clk), .reset(reset), .rdy(rdy), .irq(irq), .nmi(nmi), .I(I), .D(D),
    .cond(cond), .DB(DB), .ucode(ucode), .upc(upc), .cw(cw), .sync(sync),
    .we(we), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous microcode ROM
  logic [35:0] rom [512];
  logic [8:0]  rom_addr;
  always @(posedge clk) rom_addr <= upc;
  assign ucode = rom[rom_addr];

  function automatic logic [35:0] mk(input logic [2:0] s, input logic w, input logic [4:0] f,
                                     input logic [6:0] n, input logic [8:0] tag);
    return {s, w, 11'h2A5, tag, f, n};
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sequencer model: stack is an unbounded queue trimmed to the oldest-drop depth of 4
  logic [8:0] m_pc;
  logic [4:0] m_fin;
  logic [8:0] m_stk[$];
  logic       m_we, m_err, m_pend, m_prev, m_on;
  initial m_on = 1'b0;

  always @(negedge clk) begin : model
    logic [35:0] w;
    logic [8:0]  nx, ent, e_upc;
    logic        e_we, e_err, clr;
    clr = 1'b0;
    if (reset) begin
      chk("upc_reset", upc, RST_A);
      if (m_on) begin
        chk("we_reset", we, m_we);
        chk("err_reset", err, m_err);
      end
      m_pc = RST_A; m_fin = 5'd0; m_stk.delete();
      m_we = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_prev = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      w     = rom[m_pc];
      nx    = {1'b1, D, w[6:0]};
      ent   = m_pend ? NMI_A : (irq && !I) ? IRQ_A : {1'b0, DB};
      e_upc = m_pc;
      e_we  = m_we;
      e_err = m_err;
      if (rdy) begin
        case (w[35:33])
          S_DEC:  begin e_upc = ent; clr = m_pend; end
          S_NEXT: e_upc = nx;
          S_FIN:  e_upc = {1'b1, D, 2'b10, m_fin};
          S_SAVE: begin e_upc = nx; m_fin = w[11:7]; end
          S_BR:   e_upc = cond ? nx : m_pc + 9'd1;
`ifdef USEQ_STACK_EN
          S_CALL: begin
            m_stk.push_back(m_pc + 9'd1);
            if (m_stk.size() > 4) begin
              void'(m_stk.pop_front());
              m_err = 1'b1;
            end
            e_upc = nx;
          end
          S_RET: begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else e_upc = m_stk.pop_back();
          end
`else
          S_CALL: e_upc = nx;
          S_RET:  begin e_upc = ent; clr = m_pend; end
`endif
          default: begin
            if (m_pend || irq) begin
              e_upc = (m_pend || !I) ? ent : nx;
              clr = m_pend;
            end
          end
        endcase
      end
      chk("upc", upc, e_upc);
      chk("sync", sync, w[35:33] == S_DEC);
      chk("cw", cw, w[31:0]);
      chk("we", we, e_we);
      chk("err", err, e_err);
      if (rdy) m_we = w[32];
      if (nmi && !m_prev) m_pend = 1'b1;
      else if (clr) m_pend = 1'b0;
      m_prev = nmi;
      m_pc = e_upc;
    end
  end

  task automatic cyc(input logic r_reset, input logic r_rdy, input logic r_irq, input logic r_nmi,
                     input logic r_i, input logic r_d, input logic r_cond, input logic [7:0] r_db);
    @(posedge clk);
    #1;
    reset = r_reset; rdy = r_rdy; irq = r_irq; nmi = r_nmi;
    I = r_i; D = r_d; cond = r_cond; DB = r_db;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b1; irq = 1'b0; nmi = 1'b0; I = 1'b1; D = 1'b0; cond = 1'b0; DB = 8'h00;
    for (int i = 0; i < 512; i++) rom[i] = mk(S_NEXT, 1'b0, 5'd0, 7'h01, 9'(i));
    rom[9'h160] = mk(S_NEXT, 1'b1, 5'd0, 7'h01, 9'h160);
    rom[9'h101] = mk(S_DEC,  1'b0, 5'd0, 7'h00, 9'h101);
    rom[9'h0A9] = mk(S_SAVE, 1'b0, 5'h07, 7'h02, 9'h0A9);
    rom[9'h102] = mk(S_FIN,  1'b1, 5'd0, 7'h00, 9'h102);
    rom[9'h1C7] = mk(S_NEXT, 1'b1, 5'd0, 7'h03, 9'h1C7);
    rom[9'h103] = mk(S_NEXT, 1'b0, 5'd0, 7'h04, 9'h103);
    rom[9'h104] = mk(S_DEC,  1'b1, 5'd0, 7'h00, 9'h104);
    rom[9'h170] = mk(S_DEC,  1'b0, 5'd0, 7'h00, 9'h170);
    rom[9'h168] = mk(S_NEXT, 1'b1, 5'd0, 7'h20, 9'h168);
    rom[9'h120] = mk(S_BR,   1'b0, 5'd0, 7'h40, 9'h120);
    rom[9'h121] = mk(S_NEXT, 1'b1, 5'd0, 7'h20, 9'h121);
    rom[9'h140] = mk(S_NEXT, 1'b0, 5'd0, 7'h30, 9'h140);
    rom[9'h130] = mk(S_CALL, 1'b1, 5'd0, 7'h50, 9'h130);
    rom[9'h150] = mk(S_RET,  1'b0, 5'd0, 7'h00, 9'h150);
    rom[9'h131] = mk(S_NEXT, 1'b1, 5'd0, 7'h10, 9'h131);
    rom[9'h031] = mk(S_NEXT, 1'b1, 5'd0, 7'h10, 9'h031);
    for (int k = 0; k < 5; k++)
      rom[9'h110 + k] = mk(S_CALL, k[0], 5'd0, 7'(7'h11 + k), 9'(9'h110 + k));
    rom[9'h115] = mk(S_HALT, 1'b0, 5'd0, 7'h18, 9'h115);
    rom[9'h118] = mk(S_NEXT, 1'b1, 5'd0, 7'h19, 9'h118);
    rom[9'h119] = mk(S_RET,  1'b0, 5'd0, 7'h00, 9'h119);
    rom[9'h055] = mk(S_HALT, 1'b0, 5'd0, 7'h18, 9'h055);
    rom[9'h077] = mk(S_NEXT, 1'b1, 5'd0, 7'h7F, 9'h077);
    rom[9'h1FF] = mk(S_BR,   1'b0, 5'd0, 7'h00, 9'h1FF);

    //  reset rdy irq nmi I  D  cond DB
    cyc(1, 1, 0, 0, 1, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 1, 0, 0, 8'h00);
    chk("lit_reset_upc", upc, 9'h160); chk("lit_reset_we", we, 1'b0); chk("lit_reset_err", err, 1'b0);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_release", upc, 9'h101);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'hA9); chk("lit_decode", upc, 9'h0A9); chk("lit_sync", sync, 1'b1);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_next_save", upc, 9'h102);
    cyc(0, 1, 0, 0, 1, 1, 0, 8'h00); chk("lit_finish", upc, 9'h1C7);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_next", upc, 9'h103);
    cyc(0, 0, 0, 0, 1, 0, 0, 8'h00); chk("lit_stall1", upc, 9'h103); chk("lit_stall1_we", we, 1'b1);
    cyc(0, 0, 0, 1, 1, 0, 0, 8'h00); chk("lit_stall2", upc, 9'h103); chk("lit_stall2_we", we, 1'b1);
    cyc(0, 0, 0, 0, 1, 0, 0, 8'h00); chk("lit_stall3", upc, 9'h103); chk("lit_stall3_we", we, 1'b1);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h00); chk("lit_unstall", upc, 9'h104); chk("lit_unstall_we", we, 1'b1);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h00); chk("lit_nmi_entry", upc, 9'h170);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h00); chk("lit_irq_entry", upc, 9'h168);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_to_branch", upc, 9'h120);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_branch_nt", upc, 9'h121);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_back", upc, 9'h120);
    cyc(0, 1, 0, 0, 1, 0, 1, 8'h00); chk("lit_branch_t", upc, 9'h140);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_to_call", upc, 9'h130);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_call", upc, 9'h150);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h31);
`ifdef USEQ_STACK_EN
    chk("lit_return", upc, 9'h131);
`else
    chk("lit_return_as_decode", upc, 9'h031);
`endif
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_rejoin", upc, 9'h110);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 0, 1, 0, 0, 8'h00);
      chk("lit_nested_call", upc, 9'(9'h110 + k));
    end
    chk("lit_err_after4", err, 1'b0);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_halt1", upc, 9'h115);
`ifdef USEQ_STACK_EN
    chk("lit_err_after5", err, 1'b1);
`else
    chk("lit_err_tied", err, 1'b0);
`endif
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_halt2", upc, 9'h115);
    cyc(0, 1, 1, 0, 1, 0, 0, 8'h00); chk("lit_halt_wake_masked", upc, 9'h118);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_after_wake", upc, 9'h119);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h55);
`ifdef USEQ_STACK_EN
    chk("lit_pop_overwritten", upc, 9'h115);
    cyc(0, 1, 0, 1, 1, 0, 0, 8'h00); chk("lit_halt_nmi_edge", upc, 9'h115);
`else
    chk("lit_ret_decode", upc, 9'h055);
    cyc(0, 1, 0, 1, 1, 0, 0, 8'h00); chk("lit_halt_nmi_edge", upc, 9'h055);
`endif
    cyc(0, 1, 0, 1, 1, 0, 0, 8'h00); chk("lit_halt_nmi_wake", upc, 9'h170);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h77); chk("lit_nmi_cleared", upc, 9'h077);
    cyc(0, 1, 0, 0, 1, 1, 0, 8'h00); chk("lit_top", upc, 9'h1FF);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_wrap", upc, 9'h000);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_from_zero", upc, 9'h101);
    cyc(1, 0, 0, 0, 1, 0, 0, 8'h00); chk("lit_reset_over_rdy", upc, 9'h160);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00); chk("lit_rerelease", upc, 9'h101);
    chk("lit_rerelease_we", we, 1'b0); chk("lit_rerelease_err", err, 1'b0);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h12); chk("lit_decode2", upc, 9'h012);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
